// File: rtl/bcd_add_sequencer.sv
// ---------------------------------------------------------------------------
// bcd_add_sequencer
//
// Two-operand, two-digit BCD adder driven by a single "enter" key. The
// operator enters A, then B; the block adds them one BCD digit per cycle
// (ones in ADD_LO, tens in ADD_HI) and presents a three-digit BCD result.
// With ACCUM=1, each entry made while a result is showing is added to that
// result (running total) until the total reaches 100 or more, at which
// point the next entry reports an overflow error.
//
// Ports
//   i_clk     clock; all state changes on the rising edge
//   i_rst     synchronous, active-high reset (highest priority)
//   i_enter   single-cycle entry strobe (debounced/edge-detected upstream)
//   i_clear   synchronous operator clear (priority over i_enter)
//   i_cin     carry-in, used by the ones-digit add
//   i_digits  [7:4] BCD tens, [3:0] BCD ones
//   o_sum     [11:8] hundreds (0/1), [7:4] tens, [3:0] ones, BCD
//   o_state   current state code (IDLE=0 .. ERR=5)
//   o_busy    high while adding (ADD_LO, ADD_HI)
//   o_done    high while a result is being shown (DONE)
//   o_err     high while in ERR
// ---------------------------------------------------------------------------
module bcd_add_sequencer #(
  parameter int ACCUM = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enter,
  input  logic        i_clear,
  input  logic        i_cin,
  input  logic [7:0]  i_digits,
  output logic [11:0] o_sum,
  output logic [2:0]  o_state,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_B  = 3'd1,
    ADD_LO = 3'd2,
    ADD_HI = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam bit ACC_EN = (ACCUM != 0);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        carry;      // ones-digit carry handed from ADD_LO to ADD_HI
  logic [3:0]  ones;       // ones result held until the tens digit is ready
  logic        digits_ok;
  logic [4:0]  lo;         // {carry, digit} of the ones add
  logic [4:0]  hi;         // {hundreds, digit} of the tens add

  // One BCD digit add: binary sum, then +6 correction when it exceeds 9.
  // The correction wraps mod 16 and the decimal carry comes out on top.
  function automatic logic [4:0] digit_add(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       c);
    logic [4:0] t;
    t = {1'b0, x} + {1'b0, y} + {4'b0000, c};
    if (t > 5'd9) return {1'b1, t[3:0] + 4'd6};
    else          return {1'b0, t[3:0]};
  endfunction

  assign digits_ok = (i_digits[7:4] <= 4'd9) && (i_digits[3:0] <= 4'd9);
  assign lo        = digit_add(a[3:0], b[3:0], i_cin);
  assign hi        = digit_add(a[7:4], b[7:4], carry);

  // State code comes straight from the state register, so no input ever
  // reaches an output combinationally.
  assign o_state = state;

  // Next-state decode for the normal (not reset, not clear) case.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_enter) begin
          if (digits_ok) state_nxt = GET_B;
          else           state_nxt = ERR;
        end
      end
      GET_B: begin
        if (i_enter) begin
          if (digits_ok) state_nxt = ADD_LO;
          else           state_nxt = ERR;
        end
      end
      // Entries arriving mid-add are dropped, not queued.
      ADD_LO: state_nxt = ADD_HI;
      ADD_HI: state_nxt = DONE;
      DONE: begin
        if (i_enter) begin
          if (!digits_ok) begin
            state_nxt = ERR;
          end else if (ACC_EN) begin
            // A running total of 100+ cannot be a two-digit operand.
            if (o_sum[11:8] != 4'd0) state_nxt = ERR;
            else                     state_nxt = ADD_LO;
          end else begin
            state_nxt = GET_B;
          end
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;  // unused codes 6/7 recover to IDLE
    endcase
  end

  always_ff @(posedge i_clk) begin
    // Reset and clear have the same effect; reset simply wins if both are
    // high, and both beat a coincident i_enter.
    if (i_rst || i_clear) begin
      state  <= IDLE;
      a      <= 8'h00;
      b      <= 8'h00;
      carry  <= 1'b0;
      ones   <= 4'h0;
      o_sum  <= 12'h000;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      state  <= state_nxt;
      // Status flags are registered alongside the state they describe.
      o_busy <= (state_nxt == ADD_LO) || (state_nxt == ADD_HI);
      o_done <= (state_nxt == DONE);
      o_err  <= (state_nxt == ERR);

      case (state)
        IDLE: begin
          if (i_enter && digits_ok) a <= i_digits;
        end
        GET_B: begin
          if (i_enter && digits_ok) b <= i_digits;
        end
        ADD_LO: begin
          ones  <= lo[3:0];
          carry <= lo[4];
        end
        ADD_HI: begin
          o_sum <= {3'b000, hi[4], hi[3:0], ones};
        end
        DONE: begin
          if (i_enter && digits_ok) begin
            if (ACC_EN) begin
              if (o_sum[11:8] == 4'd0) begin
                a <= o_sum[7:0];
                b <= i_digits;
              end
            end else begin
              a <= i_digits;
            end
          end
        end
        default: ;  // ERR holds everything, including o_sum
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bcd_add_sequencer
//
// Two instances: dut 0 with ACCUM=0, dut 1 with ACCUM=1. Stimulus tasks keep
// a decimal-arithmetic model of the operator-visible behaviour and push the
// expected result (or error) into a per-instance queue; a monitor pops and
// compares whenever an instance raises o_done or o_err.
// ---------------------------------------------------------------------------
module tb_bcd_add_sequencer;

  typedef struct {
    logic        err;
    logic [11:0] sum;
  } exp_t;

  // model phases (abstract, not the RTL encoding)
  localparam int P_A = 0, P_B = 1, P_DONE = 2, P_ERR = 3;

  logic        clk;
  logic        rst    [2];
  logic        enter  [2];
  logic        clear  [2];
  logic        cin    [2];
  logic [7:0]  digits [2];
  logic [11:0] sum    [2];
  logic [2:0]  st     [2];
  logic        busy   [2];
  logic        done   [2];
  logic        err    [2];

  int   checks = 0;
  int   fails  = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   m_st  [2];
  int   m_a   [2];
  int   m_sum [2];
  logic pd [2];
  logic pe [2];

  bcd_add_sequencer #(.ACCUM(0)) dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_enter(enter[0]), .i_clear(clear[0]),
    .i_cin(cin[0]), .i_digits(digits[0]), .o_sum(sum[0]), .o_state(st[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0]));

  bcd_add_sequencer #(.ACCUM(1)) dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_enter(enter[1]), .i_clear(clear[1]),
    .i_cin(cin[1]), .i_digits(digits[1]), .o_sum(sum[1]), .o_state(st[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // decimal value of a valid two-digit BCD byte
  function automatic int dec(input logic [7:0] d);
    return int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  function automatic logic [11:0] to_bcd(input int s);
    logic [11:0] r;
    r[11:8] = 4'((s / 100) % 10);
    r[7:4]  = 4'((s / 10) % 10);
    r[3:0]  = 4'(s % 10);
    return r;
  endfunction

  function automatic bit valid(input logic [7:0] d);
    return (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
  endfunction

  task automatic push(input int w, input logic e, input logic [11:0] s);
    exp_t x;
    x.err = e;
    x.sum = s;
    if (w == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic model_reset(input int w);
    m_st[w]  = P_A;
    m_sum[w] = 0;
    m_a[w]   = 0;
    if (w == 0) q0.delete();
    else        q1.delete();
  endtask

  // Called at a negedge; pulses enter for one rising edge. If an add starts
  // and nowait is 0, returns once the result is showing.
  task automatic do_enter(input int w, input logic [7:0] d, input logic c, input bit nowait);
    bit started;
    bit acc;
    int x;
    started = 0;
    acc = (w == 1);
    x = -1;
    case (m_st[w])
      P_ERR: ;
      P_B: begin
        if (valid(d)) x = m_a[w];
        else begin m_st[w] = P_ERR; push(w, 1'b1, to_bcd(m_sum[w])); end
      end
      default: begin
        if (m_st[w] == P_DONE && acc) begin
          if (!valid(d) || m_sum[w] >= 100) begin
            m_st[w] = P_ERR; push(w, 1'b1, to_bcd(m_sum[w]));
          end else x = m_sum[w];
        end else if (valid(d)) begin
          m_a[w] = dec(d); m_st[w] = P_B;
        end else begin
          m_st[w] = P_ERR; push(w, 1'b1, to_bcd(m_sum[w]));
        end
      end
    endcase
    if (x >= 0) begin
      m_sum[w] = x + dec(d) + int'(c);
      m_st[w]  = P_DONE;
      push(w, 1'b0, to_bcd(m_sum[w]));
      started = 1;
    end
    enter[w] = 1'b1; digits[w] = d; cin[w] = c;
    @(negedge clk);
    enter[w] = 1'b0;
    if (started && !nowait) repeat (2) @(negedge clk);
  endtask

  task automatic do_clear(input int w);
    model_reset(w);
    clear[w] = 1'b1;
    @(negedge clk);
    clear[w] = 1'b0;
  endtask

  task automatic chk_idle(input string n, input int w);
    chk({n, "_state"}, st[w], 0);
    chk({n, "_sum"},   sum[w], 0);
    chk({n, "_flags"}, {busy[w], done[w], err[w]}, 0);
  endtask

  // Scoreboard monitor: any rising o_done/o_err must match the next expectation.
  always @(posedge clk) begin
    #1;
    for (int w = 0; w < 2; w++) begin
      if ((done[w] && !pd[w]) || (err[w] && !pe[w])) begin
        exp_t e;
        bit   got;
        got = 0;
        if (w == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1; end
        if (w == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1; end
        if (!got) begin
          checks++;
          fails++;
          $display("FAIL mon%0d_unexpected actual done=%0b err=%0b sum=%h expected no event",
                   w, done[w], err[w], sum[w]);
        end else begin
          chk($sformatf("mon%0d_err", w), err[w], e.err);
          chk($sformatf("mon%0d_sum", w), sum[w], e.sum);
        end
      end
      pd[w] = done[w];
      pe[w] = err[w];
    end
  end

  initial begin
    for (int w = 0; w < 2; w++) begin
      rst[w] = 1'b1; enter[w] = 1'b0; clear[w] = 1'b0; cin[w] = 1'b0;
      digits[w] = 8'h00; pd[w] = 1'b0; pe[w] = 1'b0;
      model_reset(w);
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk_idle("reset0", 0);
    chk_idle("reset1", 1);

    // 45 + 38 = 083; busy two cycles, done on the third
    do_enter(0, 8'h45, 1'b0, 0);
    do_enter(0, 8'h38, 1'b0, 1);
    chk("lat_c1_busy", {busy[0], done[0]}, 2'b10);
    chk("lat_c1_state", st[0], 2);
    @(negedge clk);
    chk("lat_c2_busy", {busy[0], done[0]}, 2'b10);
    chk("lat_c2_state", st[0], 3);
    @(negedge clk);
    chk("lat_c3_done", {busy[0], done[0]}, 2'b01);
    chk("lat_sum", sum[0], 12'h083);

    // 99 + 99 + 1 = 199, no error
    do_enter(0, 8'h99, 1'b0, 0);
    do_enter(0, 8'h99, 1'b1, 0);
    chk("max_sum", sum[0], 12'h199);
    chk("max_err", err[0], 0);

    // invalid digit -> ERR, enters ignored, clear returns to IDLE
    do_enter(0, 8'h4A, 1'b0, 0);
    chk("err_state", st[0], 5);
    chk("err_flag", err[0], 1);
    do_enter(0, 8'h11, 1'b0, 0);
    do_enter(0, 8'h22, 1'b0, 0);
    chk("err_stuck", st[0], 5);
    chk("err_sum_hold", sum[0], 12'h199);
    do_clear(0);
    chk_idle("err_clear", 0);

    // enter during ADD_LO is ignored
    do_enter(0, 8'h12, 1'b0, 0);
    do_enter(0, 8'h34, 1'b0, 1);
    enter[0] = 1'b1; digits[0] = 8'h99;
    @(negedge clk);
    enter[0] = 1'b0;
    @(negedge clk);
    chk("ign_state", st[0], 4);
    chk("ign_sum", sum[0], 12'h046);
    @(negedge clk);
    chk("ign_stay", st[0], 4);

    // clear during ADD_HI aborts, no done
    do_enter(0, 8'h12, 1'b0, 0);
    do_enter(0, 8'h34, 1'b0, 1);
    @(negedge clk);
    chk("clr_in_addhi", st[0], 3);
    do_clear(0);
    chk_idle("clr_mid", 0);
    repeat (3) @(negedge clk);
    chk("clr_no_done", done[0], 0);

    // running total
    do_enter(1, 8'h50, 1'b0, 0);
    do_enter(1, 8'h30, 1'b0, 0);
    chk("acc_80", sum[1], 12'h080);
    do_enter(1, 8'h25, 1'b0, 0);
    chk("acc_105", sum[1], 12'h105);
    do_enter(1, 8'h01, 1'b0, 0);
    chk("acc_ovf_state", st[1], 5);
    chk("acc_ovf_sum", sum[1], 12'h105);
    do_clear(1);

    // reset in GET_B with a coincident enter
    do_enter(0, 8'h12, 1'b0, 0);
    chk("rst_in_getb", st[0], 1);
    model_reset(0);
    rst[0] = 1'b1; enter[0] = 1'b1; digits[0] = 8'h34;
    @(negedge clk);
    rst[0] = 1'b0; enter[0] = 1'b0;
    chk_idle("rst_mid", 0);
    do_enter(0, 8'h01, 1'b0, 0);
    chk("rst_fresh_a", st[0], 1);
    do_enter(0, 8'h02, 1'b0, 0);
    chk("rst_fresh_sum", sum[0], 12'h003);

    // randomized traffic on both instances
    for (int i = 0; i < 160; i++) begin
      int w;
      logic [7:0] d;
      w = i % 2;
      if (m_st[w] == P_ERR || $urandom_range(0, 19) == 0) do_clear(w);
      if ($urandom_range(0, 7) == 0) d = 8'($urandom);
      else d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      do_enter(w, d, 1'($urandom), 0);
    end

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
